attex_bus_ctrl: RTL and testbench

- Sequences every SCC68070 bus cycle on the CD-i main board.
- Decodes the cycle to a target (MCD212, CDIC, slave µC, NVRAM, IACK4, bus-error region) and drives one-hot chip selects.
- Collects the target's acknowledge and registers the read data.
- Guards each cycle with a timeout that converts an unanswered access into a bus error. Sits between scc68070 and the peripherals inside cditop.

---
 rtl/attex_bus_pkg.sv | 37 +++
 rtl/attex_addr_decode.sv | 36 +++
 rtl/attex_bus_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_attex_bus_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/attex_bus_pkg.sv
// rtl/attex_bus_pkg.sv - shared types and address map for the SCC68070 bus controller
//
// Purpose : cycle targets, controller states, CD-i address map boundaries and
//           the target-to-chip-select mapping used by attex_bus_ctrl.
// Ports   : none (package).
package attex_bus_pkg;

   typedef enum logic [2:0] {
      NONE, MCD212, CDIC, SLAVE, NVRAM, IACK, BERR, ACKONLY
   } target_t;

   typedef enum logic [1:0] {
      IDLE, WAIT, END
   } state_t;

   // Byte-address boundaries of the main-board map
   localparam logic [23:0] BERR_LO      = 24'h600000;
   localparam logic [23:0] BERR_HI      = 24'hD00000;
   localparam logic [23:0] BERR_TOP     = 24'hF00000;
   localparam logic [23:0] MCD_LO_LAST  = 24'h27FFFF;
   localparam logic [23:0] MCD_HI_FIRST = 24'h400000;
   localparam logic [7:0]  CDIC_PAGE    = 8'h30;
   localparam logic [7:0]  SLAVE_PAGE   = 8'h31;
   localparam logic [7:0]  NVRAM_PAGE   = 8'h32;

   // Chip-select vector order: {mcd212, cdic, slave, nvram}
   function automatic logic [3:0] cs_onehot(input target_t t);
      case (t)
         MCD212:  return 4'b1000;
         CDIC:    return 4'b0100;
         SLAVE:   return 4'b0010;
         NVRAM:   return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/attex_addr_decode.sv
// rtl/attex_addr_decode.sv - combinational target decode of an SCC68070 bus cycle
//
// Purpose : maps the word address (and interrupt-acknowledge) to a target_t.
//           Earlier rules take priority over later ones.
// Ports   : addr   in  23  CPU address bits [23:1]
//           iack4  in   1  level-4 interrupt acknowledge
//           target out  -   decoded target_t
module attex_addr_decode
   import attex_bus_pkg::*;
(
   input  logic [22:0] addr,
   input  logic        iack4,
   output target_t     target
);

   logic [23:0] a;

   always_comb begin
      a = {addr, 1'b0};
      if (iack4)
         target = IACK;
      else if ((a >= BERR_LO && a < BERR_HI) || a >= BERR_TOP)
         target = BERR;
      else if (a[23:16] == CDIC_PAGE)
         target = CDIC;
      else if (a[23:16] == SLAVE_PAGE)
         target = SLAVE;
      else if (a[23:16] == NVRAM_PAGE)
         target = NVRAM;
      else if ((a <= MCD_LO_LAST || a >= MCD_HI_FIRST) && !a[23])
         target = MCD212;
      else
         target = ACKONLY;
   end

endmodule

// File: rtl/attex_bus_ctrl.sv
// rtl/attex_bus_ctrl.sv - SCC68070 bus-cycle sequencer for the CD-i main board
//
// Purpose : decodes each CPU bus cycle, drives one-hot chip selects, waits for
//           the target's acknowledge, registers read data and pulses
//           bus_ack / bus_err. Optional watchdog enabled by the macro
//           ATTEX_BUS_TIMEOUT_EN converts an unanswered cycle into bus_err.
// Ports   : clk30, reset (sync, active-high)
//           as, uds, lds, write_strobe, addr[22:0], iack4   CPU cycle request
//           mcd212_ack/dout, cdic_ack/dout, slave_dtack_n, slave_dout,
//           nvram_dout                                      peripheral responses
//           cs_mcd212, cs_cdic, cs_slave, cs_nvram          registered selects
//           slave_irq, data_in, bus_ack, bus_err            CPU side results
//           timeout_cnt                                     saturating timeouts
module attex_bus_ctrl
   import attex_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 11
) (
   input  logic        clk30,
   input  logic        reset,
   input  logic        as,
   input  logic        uds,
   input  logic        lds,
   input  logic        write_strobe,
   input  logic [22:0] addr,
   input  logic        iack4,
   input  logic        mcd212_ack,
   input  logic [15:0] mcd212_dout,
   input  logic        cdic_ack,
   input  logic [15:0] cdic_dout,
   input  logic        slave_dtack_n,
   input  logic [7:0]  slave_dout,
   input  logic [7:0]  nvram_dout,
   output logic        cs_mcd212,
   output logic        cs_cdic,
   output logic        cs_slave,
   output logic        cs_nvram,
   output logic        slave_irq,
   output logic [15:0] data_in,
   output logic        bus_ack,
   output logic        bus_err,
   output logic [7:0]  timeout_cnt
);

   state_t      state, state_next;
   target_t     tgt_dec, tgt_q;
   logic        write_q, wait_first, dtack_q;
   logic        start, dtack_rise, done, timed_out;
   logic [15:0] rdata;
   logic [3:0]  cs_q, cs_next;
   logic        irq_q, irq_next, ack_q, ack_next, err_q, err_next;
   logic [15:0] data_q, data_next;

   attex_addr_decode u_decode (
      .addr   (addr),
      .iack4  (iack4),
      .target (tgt_dec)
   );

   assign start      = as && (uds || lds || iack4);
   // dtack_q holds the previous sample, so a rise is a 0 then 1 sequence
   assign dtack_rise = !dtack_q && slave_dtack_n;

   // Completion condition and captured data for the latched target
   always_comb begin
      done  = 1'b0;
      rdata = 16'h0000;
      case (tgt_q)
         MCD212:  begin done = mcd212_ack; rdata = mcd212_dout;              end
         CDIC:    begin done = cdic_ack;   rdata = cdic_dout;                end
         SLAVE:   begin done = dtack_rise; rdata = {slave_dout, slave_dout}; end
         // NVRAM read data is valid one cycle after select, writes need no wait
         NVRAM:   begin done = write_q || !wait_first; rdata = {nvram_dout, nvram_dout}; end
         IACK:    begin done = 1'b1;       rdata = cdic_dout;                end
         default: done = 1'b1;
      endcase
      if (write_q)
         rdata = 16'h0000;
   end

`ifdef ATTEX_BUS_TIMEOUT_EN
   logic [TO_W-1:0] wait_cnt;
   logic [7:0]      timeout_q;

   // Counter restarts from 0 on every entry to WAIT
   always_ff @(posedge clk30) begin
      if (reset || state != WAIT)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + 1'b1;
   end

   assign timed_out = (state == WAIT) && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk30) begin
      if (reset)
         timeout_q <= 8'd0;
      else if (timed_out && as && !done && timeout_q != 8'hFF)
         timeout_q <= timeout_q + 8'd1;
   end

   assign timeout_cnt = timeout_q;
`else
   assign timed_out   = 1'b0;
   assign timeout_cnt = 8'd0;
`endif

   // FSM: state register
   always_ff @(posedge clk30) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // FSM: next state; a dropped strobe aborts WAIT ahead of any completion
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = WAIT;
         WAIT:    if (!as) state_next = IDLE;
                  else if (done || timed_out) state_next = END;
         END:     if (!as) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM: outputs (next values of the registered outputs); ack beats timeout
   always_comb begin
      cs_next   = cs_q;
      irq_next  = 1'b0;
      ack_next  = 1'b0;
      err_next  = 1'b0;
      data_next = data_q;
      case (state)
         IDLE: if (start) begin
            cs_next  = cs_onehot(tgt_dec);
            irq_next = (tgt_dec == SLAVE);
         end
         WAIT: begin
            if (!as) begin
               cs_next = 4'b0000;
            end else if (done) begin
               cs_next   = 4'b0000;
               ack_next  = (tgt_q != BERR);
               err_next  = (tgt_q == BERR);
               data_next = rdata;
            end else if (timed_out) begin
               cs_next  = 4'b0000;
               err_next = 1'b1;
            end
         end
         default: cs_next = 4'b0000;
      endcase
   end

   always_ff @(posedge clk30) begin
      if (reset) begin
         cs_q       <= 4'b0000;
         irq_q      <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         data_q     <= 16'h0000;
         tgt_q      <= NONE;
         write_q    <= 1'b0;
         wait_first <= 1'b0;
         dtack_q    <= 1'b0;
      end else begin
         cs_q       <= cs_next;
         irq_q      <= irq_next;
         ack_q      <= ack_next;
         err_q      <= err_next;
         data_q     <= data_next;
         dtack_q    <= slave_dtack_n;
         // High only during the first WAIT cycle
         wait_first <= (state == IDLE);
         if (state == IDLE && start) begin
            tgt_q   <= tgt_dec;
            write_q <= write_strobe;
         end
      end
   end

   assign {cs_mcd212, cs_cdic, cs_slave, cs_nvram} = cs_q;
   assign slave_irq = irq_q;
   assign bus_ack   = ack_q;
   assign bus_err   = err_q;
   assign data_in   = data_q;

endmodule

// File: tb/tb_attex_bus_ctrl.sv
// tb/tb_attex_bus_ctrl.sv - self-checking bench for attex_bus_ctrl
module tb_attex_bus_ctrl;
   import attex_bus_pkg::*;

   logic        clk30 = 1'b0;
   logic        reset, as, uds, lds, write_strobe, iack4;
   logic [22:0] addr;
   logic        mcd212_ack, cdic_ack, slave_dtack_n;
   logic [15:0] mcd212_dout, cdic_dout;
   logic [7:0]  slave_dout, nvram_dout;
   logic        cs_mcd212, cs_cdic, cs_slave, cs_nvram, slave_irq, bus_ack, bus_err;
   logic [15:0] data_in;
   logic [7:0]  timeout_cnt;

   logic [22:0] ref_addr;
   logic        ref_iack;
   target_t     ref_tgt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        err;
      logic [15:0] data;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   typedef struct {
      logic [23:0] a;
      logic        iack;
      logic        wr;
      target_t     tgt;
      logic [3:0]  cs;
      logic        err;
      logic [15:0] data;
   } vec_t;
   vec_t vecs[17];

   always #5 clk30 = ~clk30;

   attex_bus_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
      .clk30(clk30), .reset(reset), .as(as), .uds(uds), .lds(lds),
      .write_strobe(write_strobe), .addr(addr), .iack4(iack4),
      .mcd212_ack(mcd212_ack), .mcd212_dout(mcd212_dout),
      .cdic_ack(cdic_ack), .cdic_dout(cdic_dout),
      .slave_dtack_n(slave_dtack_n), .slave_dout(slave_dout), .nvram_dout(nvram_dout),
      .cs_mcd212(cs_mcd212), .cs_cdic(cs_cdic), .cs_slave(cs_slave), .cs_nvram(cs_nvram),
      .slave_irq(slave_irq), .data_in(data_in), .bus_ack(bus_ack), .bus_err(bus_err),
      .timeout_cnt(timeout_cnt)
   );

   attex_addr_decode u_ref (.addr(ref_addr), .iack4(ref_iack), .target(ref_tgt));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [23:0] a, input logic iack, input logic wr,
                               input target_t tgt, input logic [3:0] cs,
                               input logic err, input logic [15:0] data);
      vec_t v;
      v.a = a; v.iack = iack; v.wr = wr; v.tgt = tgt; v.cs = cs; v.err = err; v.data = data;
      return v;
   endfunction

   // Scoreboard: every response pulse must match the oldest queued expectation
   always @(negedge clk30) begin
      if (bus_ack || bus_err) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", {30'd0, bus_ack, bus_err}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("resp_kind", {30'd0, bus_ack, bus_err}, {30'd0, !mon_e.err, mon_e.err});
            if (!mon_e.err)
               check("resp_data", {16'd0, data_in}, {16'd0, mon_e.data});
         end
      end
   end

   task automatic strobe(input logic [23:0] a, input logic wr);
      addr = a[23:1]; write_strobe = wr; iack4 = 1'b0; uds = 1'b1; lds = 1'b1; as = 1'b1;
   endtask

   task automatic end_access();
      as = 1'b0; uds = 1'b0; lds = 1'b0; iack4 = 1'b0; write_strobe = 1'b0;
      @(negedge clk30);
   endtask

   task automatic run_access(input vec_t v, input string name);
      logic [3:0] seen;
      bit got;
      seen = 4'b0000;
      got  = 0;
      @(negedge clk30);
      addr = v.a[23:1]; iack4 = v.iack; write_strobe = v.wr;
      uds = !v.iack; lds = !v.iack; as = 1'b1;
      sb.push_back('{err: v.err, data: v.data});
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk30);
         seen |= {cs_mcd212, cs_cdic, cs_slave, cs_nvram};
         if (bus_ack || bus_err)
            got = 1;
         else begin
            // Responders answer one cycle after seeing their select
            mcd212_ack = cs_mcd212; cdic_ack = cs_cdic; slave_dtack_n = cs_slave;
         end
      end
      mcd212_ack = 1'b0; cdic_ack = 1'b0; slave_dtack_n = 1'b0;
      check({name, "_done"}, {31'd0, got}, 32'd1);
      if (!got) void'(sb.pop_back());
      check({name, "_cs"}, {28'd0, seen}, {28'd0, v.cs});
      @(negedge clk30);
      check({name, "_pulse"}, {30'd0, bus_ack, bus_err}, 32'd0);
      end_access();
   endtask

   initial begin
      reset = 1'b1; as = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0; iack4 = 1'b0;
      addr = '0; mcd212_ack = 1'b0; cdic_ack = 1'b0; slave_dtack_n = 1'b0;
      mcd212_dout = 16'h1234; cdic_dout = 16'hBEEF; slave_dout = 8'h81; nvram_dout = 8'h5A;
      ref_addr = '0; ref_iack = 1'b0;

      vecs[0]  = mk(24'h000100, 0, 0, MCD212,  4'b1000, 0, 16'h1234);
      vecs[1]  = mk(24'h27FFFE, 0, 0, MCD212,  4'b1000, 0, 16'h1234);
      vecs[2]  = mk(24'h280000, 0, 0, ACKONLY, 4'b0000, 0, 16'h0000);
      vecs[3]  = mk(24'h303C00, 0, 0, CDIC,    4'b0100, 0, 16'hBEEF);
      vecs[4]  = mk(24'h310002, 0, 0, SLAVE,   4'b0010, 0, 16'h8181);
      vecs[5]  = mk(24'h320010, 0, 0, NVRAM,   4'b0001, 0, 16'h5A5A);
      vecs[6]  = mk(24'h320010, 0, 1, NVRAM,   4'b0001, 0, 16'h0000);
      vecs[7]  = mk(24'h3FFFFE, 0, 0, ACKONLY, 4'b0000, 0, 16'h0000);
      vecs[8]  = mk(24'h400000, 0, 0, MCD212,  4'b1000, 0, 16'h1234);
      vecs[9]  = mk(24'h5FFFFE, 0, 1, MCD212,  4'b1000, 0, 16'h0000);
      vecs[10] = mk(24'h600000, 0, 0, BERR,    4'b0000, 1, 16'h0000);
      vecs[11] = mk(24'h700000, 0, 0, BERR,    4'b0000, 1, 16'h0000);
      vecs[12] = mk(24'hCFFFFE, 0, 0, BERR,    4'b0000, 1, 16'h0000);
      vecs[13] = mk(24'hD00000, 0, 0, ACKONLY, 4'b0000, 0, 16'h0000);
      vecs[14] = mk(24'hEFFFFE, 0, 0, ACKONLY, 4'b0000, 0, 16'h0000);
      vecs[15] = mk(24'hF00000, 0, 0, BERR,    4'b0000, 1, 16'h0000);
      vecs[16] = mk(24'h303C00, 1, 0, IACK,    4'b0000, 0, 16'hBEEF);

      repeat (3) @(negedge clk30);
      reset = 1'b0;
      @(negedge clk30);
      check("rst_cs",   {28'd0, cs_mcd212, cs_cdic, cs_slave, cs_nvram}, 32'd0);
      check("rst_puls", {29'd0, bus_ack, bus_err, slave_irq}, 32'd0);
      check("rst_data", {16'd0, data_in}, 32'd0);
      check("rst_tcnt", {24'd0, timeout_cnt}, 32'd0);

      for (int i = 0; i < 17; i++) begin
         ref_addr = vecs[i].a[23:1]; ref_iack = vecs[i].iack;
         #1;
         check($sformatf("vec%0d_decode", i), {29'd0, ref_tgt}, {29'd0, vecs[i].tgt});
         run_access(vecs[i], $sformatf("vec%0d", i));
      end

      // CDIC read, ack raised 3 cycles after the strobe
      @(negedge clk30);
      strobe(24'h303C00, 1'b0);
      sb.push_back('{err: 1'b0, data: 16'hBEEF});
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk30);
         check("cdic_cs", {31'd0, cs_cdic}, 32'd1);
         check("cdic_early", {31'd0, bus_ack}, 32'd0);
         if (i == 3) cdic_ack = 1'b1;
      end
      @(negedge clk30);
      cdic_ack = 1'b0;
      check("cdic_ack",  {31'd0, bus_ack}, 32'd1);
      check("cdic_drop", {31'd0, cs_cdic}, 32'd0);
      check("cdic_data", {16'd0, data_in}, 32'h0000BEEF);
      @(negedge clk30);
      check("cdic_end_puls", {30'd0, bus_ack, bus_err}, 32'd0);
      check("cdic_end_hold", {16'd0, data_in}, 32'h0000BEEF);
      end_access();

      // NVRAM read completes on the second WAIT cycle, write on the first
      @(negedge clk30);
      strobe(24'h320010, 1'b0);
      sb.push_back('{err: 1'b0, data: 16'h5A5A});
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk30);
         check($sformatf("nvr_rd_c%0d", i), {31'd0, bus_ack}, {31'd0, i == 3});
      end
      check("nvr_rd_data", {16'd0, data_in}, 32'h00005A5A);
      end_access();
      @(negedge clk30);
      strobe(24'h320010, 1'b1);
      sb.push_back('{err: 1'b0, data: 16'h0000});
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk30);
         check($sformatf("nvr_wr_c%0d", i), {31'd0, bus_ack}, {31'd0, i == 2});
      end
      check("nvr_wr_data", {16'd0, data_in}, 32'd0);
      end_access();

      // Slave read, dtack rises after 5 cycles
      @(negedge clk30);
      slave_dtack_n = 1'b0;
      strobe(24'h310002, 1'b0);
      sb.push_back('{err: 1'b0, data: 16'h8181});
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk30);
         check($sformatf("slv_irq_c%0d", i), {31'd0, slave_irq}, {31'd0, i == 1});
         check("slv_cs", {31'd0, cs_slave}, 32'd1);
         check("slv_early", {31'd0, bus_ack}, 32'd0);
         if (i == 5) slave_dtack_n = 1'b1;
      end
      @(negedge clk30);
      check("slv_ack",  {31'd0, bus_ack}, 32'd1);
      check("slv_data", {16'd0, data_in}, 32'h00008181);
      slave_dtack_n = 1'b0;
      end_access();

      // Unanswered MCD212 access
      @(negedge clk30);
      strobe(24'h000100, 1'b0);
`ifdef ATTEX_BUS_TIMEOUT_EN
      sb.push_back('{err: 1'b1, data: 16'h0000});
      for (int i = 1; i <= 17; i++) begin
         @(negedge clk30);
         check($sformatf("to_err_c%0d", i), {31'd0, bus_err}, {31'd0, i == 17});
      end
      @(negedge clk30);
      check("to_cnt", {24'd0, timeout_cnt}, 32'd1);
`else
      begin
         bit seen_err;
         seen_err = 0;
         for (int i = 0; i < 2000; i++) begin
            @(negedge clk30);
            if (bus_err || bus_ack) seen_err = 1;
         end
         check("no_timeout", {31'd0, seen_err}, 32'd0);
         check("no_to_cs",   {31'd0, cs_mcd212}, 32'd1);
         check("no_to_cnt",  {24'd0, timeout_cnt}, 32'd0);
      end
`endif
      end_access();

      // as dropped mid-WAIT on CDIC: abort, late ack ignored
      @(negedge clk30);
      strobe(24'h303C00, 1'b0);
      @(negedge clk30);
      check("abt_cs_on", {31'd0, cs_cdic}, 32'd1);
      as = 1'b0; uds = 1'b0; lds = 1'b0;
      @(negedge clk30);
      check("abt_cs_off", {31'd0, cs_cdic}, 32'd0);
      cdic_ack = 1'b1;
      @(negedge clk30);
      check("abt_puls", {30'd0, bus_ack, bus_err}, 32'd0);
      cdic_ack = 1'b0;

      // reset mid-cycle on a new MCD212 access
      @(negedge clk30);
      strobe(24'h000100, 1'b0);
      @(negedge clk30);
      check("rmid_cs_on", {31'd0, cs_mcd212}, 32'd1);
      reset = 1'b1; mcd212_ack = 1'b1;
      @(negedge clk30);
      check("rmid_cs",   {28'd0, cs_mcd212, cs_cdic, cs_slave, cs_nvram}, 32'd0);
      check("rmid_puls", {29'd0, bus_ack, bus_err, slave_irq}, 32'd0);
      check("rmid_data", {16'd0, data_in}, 32'd0);
      check("rmid_tcnt", {24'd0, timeout_cnt}, 32'd0);
      reset = 1'b0; mcd212_ack = 1'b0;
      end_access();
      run_access(vecs[5], "post_rst");

      check("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
